// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem address, IF/ID pipeline register and boot sequencing.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect targets trap instead of
// being word-aligned).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_pc_o,
  input  logic [31:0] imem_inst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc4_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o,
  output logic        if_misalign_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StRun   = 2'd1,
    StStall = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    StTrap  = 2'd3
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        bubble;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        if_misalign_q, if_misalign_d;
  assign target = redirect_pc_i;
`else
  logic        unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
  assign target = {redirect_pc_i[31:2], 2'b00};
`endif

  // Wraps modulo 2^32 by construction.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_pc4_d   = if_pc4_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    count_d    = count_q;
    bubble     = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    if_misalign_d = if_misalign_q;
`endif

    case (state_q)
      StBoot: begin
        bubble  = 1'b1;
        state_d = StRun;
        if (redirect_i) begin
          pc_d = target;
        end
      end

      StRun, StStall: begin
        if (redirect_i) begin
          pc_d    = target;
          bubble  = 1'b1;
          state_d = StRun;
        end else if (stall_i) begin
          state_d = StStall;
        end else begin
          state_d    = StRun;
          if_pc_d    = pc_q;
          if_pc4_d   = pc_plus4;
          if_valid_d = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (pc_q[1:0] != 2'b00) begin
            // Trap slot carries the faulting PC but no instruction and is not counted.
            if_inst_d     = NOP_INST;
            if_misalign_d = 1'b1;
            state_d       = StTrap;
          end else begin
            if_inst_d     = imem_inst_i;
            if_misalign_d = 1'b0;
            pc_d          = pc_plus4;
            count_d       = count_q + 32'd1;
          end
`else
          if_inst_d = imem_inst_i;
          pc_d      = pc_plus4;
          count_d   = count_q + 32'd1;
`endif
        end
      end

`ifdef FETCH_MISALIGN_TRAP_EN
      StTrap: begin
        // PC stays frozen until a redirect; stall has no effect here.
        bubble = 1'b1;
        if (redirect_i) begin
          pc_d    = target;
          state_d = StRun;
        end
      end
`endif

      default: begin
        bubble  = 1'b1;
        state_d = StRun;
      end
    endcase

    // A bubble leaves if_pc/if_pc4 untouched; only the payload is invalidated.
    if (bubble) begin
      if_inst_d  = NOP_INST;
      if_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if_misalign_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      if_pc_q    <= 32'h0;
      if_pc4_q   <= 32'h0;
      if_inst_q  <= NOP_INST;
      if_valid_q <= 1'b0;
      count_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_pc4_q   <= if_pc4_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      count_q    <= count_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if_misalign_q <= 1'b0;
    end else begin
      if_misalign_q <= if_misalign_d;
    end
  end
  assign if_misalign_o = if_misalign_q;
`else
  assign if_misalign_o = 1'b0;
`endif

  assign imem_pc_o     = pc_q;
  assign if_pc_o       = if_pc_q;
  assign if_pc4_o      = if_pc4_q;
  assign if_inst_o     = if_inst_q;
  assign if_valid_o    = if_valid_q;
  assign fetch_count_o = count_q;

endmodule
